// File: rtl/sample_io_if.sv
// Sample-stream bundle between the rate-converter controller/datapath and the I/O bridge.
// The master side drives strobes and stream inputs; the slave side is the bridge.
interface sample_io_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              en;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              new_in;
  logic [DATA_W-1:0] in_sample;
  logic              in_vld;
  logic              new_out;
  logic [DATA_W-1:0] out_sample;
  logic              stall;
  logic              proto_err;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output en, s_data, s_valid, m_ready, new_in, new_out, out_sample,
    input  s_ready, m_data, m_valid, in_sample, in_vld, stall, proto_err, in_cnt, out_cnt
  );

  modport slave (
    input  en, s_data, s_valid, m_ready, new_in, new_out, out_sample,
    output s_ready, m_data, m_valid, in_sample, in_vld, stall, proto_err, in_cnt, out_cnt
  );
endinterface

// File: rtl/sample_io_bridge.sv
// Input/output sample FIFOs for the sample rate converter, servicing the controller's
// new_in/new_out strobes and flagging stall while a request waits on data or space.
module sample_io_bridge #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  sample_io_if.slave    bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_e;

  req_state_e        in_state_q, in_state_d;
  req_state_e        out_state_q, out_state_d;
  logic [PTR_W-1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [PTR_W-1:0]  out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] in_sample_q, in_sample_d;
  logic              in_vld_q, in_vld_d;
  logic              proto_err_q, proto_err_d;

  logic [DATA_W-1:0] in_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];

  logic              s_ready_int;
  logic              m_valid_int;
  logic              in_push, in_pop, in_empty;
  logic              out_push, out_pop, out_full;
  logic [DATA_W-1:0] out_push_data;
  logic              in_strobe, out_strobe;

  // Full/empty use registered counts only, so s_ready never depends on a same-cycle pop.
  assign in_empty    = (in_cnt_q == '0);
  assign out_full    = (out_cnt_q == CNT_W'(DEPTH));
  assign s_ready_int = !rst && (in_cnt_q != CNT_W'(DEPTH));
  assign m_valid_int = (out_cnt_q != '0);
  assign in_push     = bus.s_valid && s_ready_int;
  assign out_pop     = m_valid_int && bus.m_ready;
  assign in_strobe   = bus.new_in && bus.en;
  assign out_strobe  = bus.new_out && bus.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q   <= REQ_IDLE;
      out_state_q  <= REQ_IDLE;
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      hold_q       <= '0;
      in_sample_q  <= '0;
      in_vld_q     <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      hold_q       <= hold_d;
      in_sample_q  <= in_sample_d;
      in_vld_q     <= in_vld_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by the counts alone.
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wr_ptr_q] <= bus.s_data;
    end
    if (out_push) begin
      out_mem[out_wr_ptr_q] <= out_push_data;
    end
  end

  always_comb begin
    in_state_d    = in_state_q;
    out_state_d   = out_state_q;
    hold_d        = hold_q;
    proto_err_d   = proto_err_q;
    in_pop        = 1'b0;
    out_push      = 1'b0;
    out_push_data = bus.out_sample;

    // A pending request completes on the first cycle it can, regardless of en.
    case (in_state_q)
      REQ_IDLE: begin
        if (in_strobe) begin
          if (!in_empty) begin
            in_pop = 1'b1;
          end else begin
            in_state_d = REQ_PEND;
          end
        end
      end
      REQ_PEND: begin
        if (in_strobe) begin
          proto_err_d = 1'b1;
        end
        if (!in_empty) begin
          in_pop     = 1'b1;
          in_state_d = REQ_IDLE;
        end
      end
      default: in_state_d = REQ_IDLE;
    endcase

    case (out_state_q)
      REQ_IDLE: begin
        if (out_strobe) begin
          if (!out_full) begin
            out_push = 1'b1;
          end else begin
            hold_d      = bus.out_sample;
            out_state_d = REQ_PEND;
          end
        end
      end
      REQ_PEND: begin
        if (out_strobe) begin
          proto_err_d = 1'b1;
        end
        if (!out_full) begin
          out_push      = 1'b1;
          out_push_data = hold_q;
          out_state_d   = REQ_IDLE;
        end
      end
      default: out_state_d = REQ_IDLE;
    endcase

    in_vld_d     = in_pop;
    in_sample_d  = in_pop ? in_mem[in_rd_ptr_q] : in_sample_q;
    in_wr_ptr_d  = in_push  ? in_wr_ptr_q + PTR_W'(1)  : in_wr_ptr_q;
    in_rd_ptr_d  = in_pop   ? in_rd_ptr_q + PTR_W'(1)  : in_rd_ptr_q;
    out_wr_ptr_d = out_push ? out_wr_ptr_q + PTR_W'(1) : out_wr_ptr_q;
    out_rd_ptr_d = out_pop  ? out_rd_ptr_q + PTR_W'(1) : out_rd_ptr_q;
    in_cnt_d     = in_cnt_q + CNT_W'(in_push) - CNT_W'(in_pop);
    out_cnt_d    = out_cnt_q + CNT_W'(out_push) - CNT_W'(out_pop);
  end

  assign bus.s_ready   = s_ready_int;
  assign bus.m_valid   = m_valid_int;
  assign bus.m_data    = out_mem[out_rd_ptr_q];
  assign bus.in_sample = in_sample_q;
  assign bus.in_vld    = in_vld_q;
  assign bus.stall     = (in_state_q == REQ_PEND) || (out_state_q == REQ_PEND);
  assign bus.proto_err = proto_err_q;
  assign bus.in_cnt    = in_cnt_q;
  assign bus.out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_sample_io_bridge.sv
// Self-checking bench for sample_io_bridge: queue-based reference model, scoreboard
// monitor on the falling edge, directed scenarios followed by randomized traffic.
module tb_sample_io_bridge;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_io_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sample_io_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: plain queues plus request bookkeeping.
  logic [DATA_W-1:0] m_in_q[$];
  logic [DATA_W-1:0] m_out_q[$];
  logic [DATA_W-1:0] sb_in[$];
  logic              m_in_pend  = 1'b0;
  logic              m_out_pend = 1'b0;
  logic              m_perr     = 1'b0;
  logic              m_exp_vld  = 1'b0;
  logic [DATA_W-1:0] m_hold     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_q.delete();
      m_out_q.delete();
      sb_in.delete();
      m_in_pend  = 1'b0;
      m_out_pend = 1'b0;
      m_perr     = 1'b0;
      m_exp_vld  = 1'b0;
      m_hold     = '0;
    end else begin
      bit in_acc;
      bit out_full;
      in_acc    = bus.s_valid && (m_in_q.size() != DEPTH);
      out_full  = (m_out_q.size() == DEPTH);
      m_exp_vld = 1'b0;
      if (bus.new_in && bus.en && m_in_pend) m_perr = 1'b1;
      if (bus.new_out && bus.en && m_out_pend) m_perr = 1'b1;
      // Input side: a request takes the oldest buffered sample, or waits for one.
      if (m_in_pend || (bus.new_in && bus.en)) begin
        if (m_in_q.size() != 0) begin
          sb_in.push_back(m_in_q.pop_front());
          m_exp_vld = 1'b1;
          m_in_pend = 1'b0;
        end else begin
          m_in_pend = 1'b1;
        end
      end
      if (in_acc) m_in_q.push_back(bus.s_data);
      // Output side: pop decided on pre-edge occupancy, push refused when it was full.
      if (m_out_q.size() != 0 && bus.m_ready) m_out_q.delete(0);
      if (m_out_pend) begin
        if (!out_full) begin
          m_out_q.push_back(m_hold);
          m_out_pend = 1'b0;
        end
      end else if (bus.new_out && bus.en) begin
        if (!out_full) m_out_q.push_back(bus.out_sample);
        else begin
          m_hold     = bus.out_sample;
          m_out_pend = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every cycle against the model, pops scoreboard on in_vld.
  always @(negedge clk) begin
    if (!rst) begin
      check("s_ready",   32'(bus.s_ready),   32'(m_in_q.size() != DEPTH));
      check("in_cnt",    32'(bus.in_cnt),    32'(m_in_q.size()));
      check("out_cnt",   32'(bus.out_cnt),   32'(m_out_q.size()));
      check("m_valid",   32'(bus.m_valid),   32'(m_out_q.size() != 0));
      check("stall",     32'(bus.stall),     32'(m_in_pend | m_out_pend));
      check("proto_err", 32'(bus.proto_err), 32'(m_perr));
      check("in_vld",    32'(bus.in_vld),    32'(m_exp_vld));
      if (bus.in_vld) begin
        if (sb_in.size() == 0) begin
          n_checks++;
          $display("FAIL in_sample: got 0x%0h with no sample expected at %0t", bus.in_sample, $time);
        end else begin
          check("in_sample", 32'(bus.in_sample), 32'(sb_in.pop_front()));
        end
      end
      if (bus.m_valid && bus.m_ready && m_out_q.size() != 0)
        check("m_data", 32'(bus.m_data), 32'(m_out_q[0]));
    end
  end

  initial begin
    bus.en         = 1'b1;
    bus.s_valid    = 1'b1;
    bus.s_data     = 16'h0000;
    bus.m_ready    = 1'b0;
    bus.new_in     = 1'b0;
    bus.new_out    = 1'b0;
    bus.out_sample = 16'h0000;
    rst            = 1'b1;

    // Reset held with s_valid high
    repeat (3) cyc();
    check("rst_s_ready",   32'(bus.s_ready),   32'd0);
    check("rst_m_valid",   32'(bus.m_valid),   32'd0);
    check("rst_in_vld",    32'(bus.in_vld),    32'd0);
    check("rst_in_sample", 32'(bus.in_sample), 32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_proto_err", 32'(bus.proto_err), 32'd0);
    check("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rel_s_ready", 32'(bus.s_ready), 32'd1);
    check("rel_in_cnt",  32'(bus.in_cnt),  32'd0);
    cyc();

    // Input ordering and fill to full
    for (int i = 1; i <= 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(i * 16'h0011);
      cyc();
    end
    bus.s_valid = 1'b0;
    repeat (3) begin
      bus.new_in = 1'b1; cyc();
      bus.new_in = 1'b0; cyc();
    end
    for (int i = 4; i <= 7; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(i * 16'h0011);
      cyc();
    end
    bus.s_valid = 1'b0;
    check("full_s_ready", 32'(bus.s_ready), 32'd0);
    check("full_in_cnt",  32'(bus.in_cnt),  32'd4);
    repeat (4) begin
      bus.new_in = 1'b1; cyc();
      bus.new_in = 1'b0; cyc();
    end

    // Input underrun: request on empty FIFO then late sample
    bus.new_in = 1'b1; cyc();
    bus.new_in = 1'b0; cyc();
    check("underrun_stall", 32'(bus.stall), 32'd1);
    cyc();
    bus.s_valid = 1'b1; bus.s_data = 16'h0ABC; cyc();
    bus.s_valid = 1'b0;
    check("underrun_wait_vld",   32'(bus.in_vld), 32'd0);
    check("underrun_wait_stall", 32'(bus.stall),  32'd1);
    cyc();
    check("underrun_vld",    32'(bus.in_vld),    32'd1);
    check("underrun_sample", 32'(bus.in_sample), 32'h0ABC);
    check("underrun_clear",  32'(bus.stall),     32'd0);
    repeat (2) cyc();

    // Output overrun with sink stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.new_out    = 1'b1;
      bus.out_sample = DATA_W'(16'h1000 + i);
      cyc();
    end
    bus.new_out = 1'b0;
    check("overrun_out_cnt", 32'(bus.out_cnt), 32'd4);
    check("overrun_stall",   32'(bus.stall),   32'd1);
    check("overrun_head",    32'(bus.m_data),  32'h1000);
    bus.m_ready = 1'b1;
    cyc();
    check("overrun_stall_pop", 32'(bus.stall), 32'd1);
    cyc();
    check("overrun_stall_clr", 32'(bus.stall), 32'd0);
    repeat (6) cyc();
    check("overrun_drained", 32'(bus.m_valid), 32'd0);

    // Protocol error: repeated new_in while pending
    bus.new_in = 1'b1;
    repeat (3) cyc();
    bus.new_in = 1'b0;
    cyc();
    bus.s_valid = 1'b1; bus.s_data = 16'h0555; cyc();
    bus.s_valid = 1'b0;
    repeat (3) cyc();
    check("perr_set", 32'(bus.proto_err), 32'd1);
    repeat (3) cyc();
    check("perr_sticky", 32'(bus.proto_err), 32'd1);

    // Async reset mid-stream
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.new_out    = 1'b1;
      bus.out_sample = DATA_W'(16'h2000 + i);
      cyc();
    end
    bus.new_out = 1'b0;
    bus.new_in  = 1'b1; cyc();
    bus.new_in  = 1'b0; cyc();
    check("pre_rst_out_cnt", 32'(bus.out_cnt), 32'd3);
    check("pre_rst_stall",   32'(bus.stall),   32'd1);
    rst = 1'b1;
    #1;
    check("arst_m_valid",   32'(bus.m_valid),   32'd0);
    check("arst_out_cnt",   32'(bus.out_cnt),   32'd0);
    check("arst_stall",     32'(bus.stall),     32'd0);
    check("arst_proto_err", 32'(bus.proto_err), 32'd0);
    check("arst_s_ready",   32'(bus.s_ready),   32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.en         = ($urandom_range(0, 9) != 0);
      bus.s_valid    = 1'($urandom_range(0, 1));
      bus.s_data     = DATA_W'($urandom);
      bus.m_ready    = ($urandom_range(0, 2) != 0);
      bus.new_in     = ($urandom_range(0, 3) == 0);
      bus.new_out    = ($urandom_range(0, 3) == 0);
      bus.out_sample = DATA_W'($urandom);
      cyc();
    end

    // Quiesce: feed samples to satisfy any waiting request, drain the sink
    bus.en      = 1'b1;
    bus.new_in  = 1'b0;
    bus.new_out = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h7E57;
    cyc();
    bus.s_valid = 1'b0;
    repeat (8) cyc();
    check("final_out_empty", 32'(bus.m_valid),   32'd0);
    check("final_sb_empty",  32'(sb_in.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sample_io_bridge.md
# sample_io_bridge

Sample-stream front/back end of the sample rate converter core. Services the controller's `new_in` (request next input sample) and `new_out` (emit output sample) strobes: buffers samples arriving from the upstream source in an input FIFO and delivers them to the register-file write path, and buffers samples read from the register file in an output FIFO drained by the downstream sink. Asserts `stall` so the controller can hold `en` low while a request cannot yet be serviced.

## Interface
- `DATA_W`, 16, sample width in bits
- `DEPTH`, 4, entries per FIFO; power of two, ≥ 2
- `CNT_W`, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  core enable; gates acceptance of new `new_in`/`new_out` strobes only
- `s_data`  in  DATA_W  upstream sample
- `s_valid`  in  1  upstream sample valid
- `s_ready`  out  1  input FIFO can accept
- `m_data`  out  DATA_W  downstream sample (head of output FIFO)
- `m_valid`  out  1  output FIFO non-empty
- `m_ready`  in  1  downstream accepts
- `new_in`  in  1  controller request for next input sample
- `in_sample`  out  DATA_W  sample delivered to register-file write port
- `in_vld`  out  1  one-cycle strobe, `in_sample` valid
- `new_out`  in  1  controller request to emit `out_sample`
- `out_sample`  in  DATA_W  sample read from register file, valid with `new_out`
- `stall`  out  1  a request is pending and unserviced
- `proto_err`  out  1  sticky: strobe received while same-direction request pending
- `in_cnt`, `out_cnt`  out  CNT_W  FIFO occupancies

## Operation
- Reset values: `s_ready`=0 while `rst`=1, else (`in_cnt`≠DEPTH); `m_valid`=0, `m_data`=head (don't-care when empty), `in_sample`=0, `in_vld`=0, `stall`=0, `proto_err`=0, `in_cnt`=`out_cnt`=0; pointers, pending flags, holding register cleared.
- Strobes `new_in`/`new_out` are level-sampled at posedge; one sample per cycle asserted with `en`=1.
- Input FIFO: push on `s_valid && s_ready`. `s_ready` depends only on registered `in_cnt` (no path from pops).
- Input request: accepted when `new_in && en`. If `in_cnt`>0 → pop head into `in_sample`, `in_vld`=1 next cycle. If `in_cnt`=0 → set `in_pend`; `in_pend` services on the first cycle `in_cnt`>0 (independent of `en`), then clears.
- Output request: accepted when `new_out && en`. If `out_cnt`<DEPTH → push `out_sample`. Else capture `out_sample` into holding register, set `out_pend`; push from holding register on first cycle `out_cnt`<DEPTH (independent of `en`).
- Output FIFO pop on `m_valid && m_ready`; `m_valid`=(`out_cnt`≠0).
- Full/empty decisions use registered counts: push on full-with-simultaneous-pop is refused (output side goes pending); pop on empty-with-simultaneous-push is refused (input side goes pending).
- Simultaneous push and pop on non-full/non-empty FIFO: count unchanged, both complete.
- `stall` = `in_pend | out_pend` (registered state, combinational OR).
- `new_in` while `in_pend`, or `new_out` while `out_pend`: strobe dropped, `proto_err` set until reset.
- Pointers wrap modulo DEPTH; counts saturate logically at DEPTH by construction.
- `rst` mid-operation: all FIFO contents and pending requests discarded immediately.

## Timing
- Upstream → FIFO: sample accepted at edge t is poppable at edge t+1; earliest `in_vld` at t+2.
- `new_in` at edge t with data present: `in_vld`/`in_sample` valid in cycle after t (1-cycle latency).
- Pending input: sample accepted at edge t → `in_vld` after edge t+1; `stall` falls same cycle `in_vld` rises.
- `new_out` at edge t with space: `m_valid` high after edge t.
- Pending output: space appears at edge t (pop) → push at edge t+1; `stall` low after t+1.
- `stall` rises the cycle after the unserviceable strobe edge.

## Test plan
- Reset: hold `rst`=1, drive `s_valid`=1 → `s_ready`=0, all outputs at reset values; release → `s_ready`=1, `in_cnt`=0.
- Input ordering: push 0x0011,0x0022,0x0033; pulse `new_in` three times → `in_sample`=0x0011,0x0022,0x0033 in order, each with one-cycle `in_vld`; push 4 more with no pops → `s_ready`=0 at `in_cnt`=4.
- Input underrun: `new_in` with empty FIFO → `stall`=1; push 0x0ABC two cycles later → `in_vld`=1 with 0x0ABC two edges after push, `stall`=0 that cycle.
- Output overrun: `m_ready`=0, five `new_out` with 0x1000..0x1004 → `out_cnt`=4, `stall`=1; raise `m_ready` → `m_data` sequence 0x1000..0x1004, `stall` clears after first pop +1 edge.
- Protocol error: `new_in` twice while `in_pend` → `proto_err`=1, only one `in_vld` produced; persists until `rst`.
- Async reset mid-stream: assert `rst` between edges with `out_cnt`=3, `stall`=1 → outputs clear immediately without clock edge, `m_valid`=0.
